// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage bit indices,
// bus types, FSM state encodings, fixed stall/flush patterns and the
// load-use detection helper.
package pipe_hazard_ctrl_pkg;

  // Bit positions on the stall/flush buses
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_WB    = 4;

  localparam int STALL_W = 5;
  localparam int FLUSH_W = 5;

  typedef logic [STALL_W-1:0] stall_bus_t;
  typedef logic [FLUSH_W-1:0] flush_bus_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

  // Data access outstanding: freeze everything up to EX/MEM, bubble into MEM/WB
  localparam stall_bus_t STALL_DWAIT = stall_bus_t'((32'd1 << STG_PC) | (32'd1 << STG_IFID) |
                                                    (32'd1 << STG_IDEX) | (32'd1 << STG_EXMEM));
  localparam flush_bus_t FLUSH_DWAIT = flush_bus_t'(32'd1 << STG_WB);
  // Redirect: kill the two wrong-path instructions behind the branch
  localparam flush_bus_t FLUSH_REDIRECT = flush_bus_t'((32'd1 << STG_IFID) | (32'd1 << STG_IDEX));
  // Load-use: hold PC and IF/ID, bubble into ID/EX
  localparam stall_bus_t STALL_LOADUSE = stall_bus_t'((32'd1 << STG_PC) | (32'd1 << STG_IFID));
  localparam flush_bus_t FLUSH_LOADUSE = flush_bus_t'(32'd1 << STG_IDEX);
  // Fetch squash / fetch wait: keep IF/ID empty
  localparam flush_bus_t FLUSH_SQUASH = flush_bus_t'(32'd1 << STG_IFID);
  localparam stall_bus_t STALL_IMEM   = stall_bus_t'(32'd1 << STG_PC);
  // Every stage register cleared while in reset
  localparam flush_bus_t FLUSH_RESET  = 5'b11111;

  // True when the instruction in ID reads the register a load in EX writes
  function automatic logic load_use_hit(
    input logic       ex_mem_re,
    input logic [4:0] ex_rd,
    input logic [4:0] r1,
    input logic       use_r1,
    input logic [4:0] r2,
    input logic       use_r2
  );
    return ex_mem_re && (ex_rd != 5'd0) &&
           ((use_r1 && (r1 == ex_rd)) || (use_r2 && (r2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status inputs and the stall/flush buses.
// The controller uses the slave view; the pipeline (or a bench) drives the master view.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic [4:0]  id_r1_i;
  logic [4:0]  id_r2_i;
  logic        id_use_r1_i;
  logic        id_use_r2_i;
  logic [4:0]  ex_rd_i;
  logic        ex_mem_re_i;
  logic        ex_redirect_i;
  logic        mem_access_i;
  logic        dmem_ack_i;
  logic        imem_ack_i;
  stall_bus_t  stall_o;
  flush_bus_t  flush_o;
  logic [31:0] stall_cycles_o;
  logic        bus_err_o;

  modport master (
    output id_r1_i, id_r2_i, id_use_r1_i, id_use_r2_i, ex_rd_i, ex_mem_re_i,
           ex_redirect_i, mem_access_i, dmem_ack_i, imem_ack_i,
    input  stall_o, flush_o, stall_cycles_o, bus_err_o
  );

  modport slave (
    input  id_r1_i, id_r2_i, id_use_r1_i, id_use_r2_i, ex_rd_i, ex_mem_re_i,
           ex_redirect_i, mem_access_i, dmem_ack_i, imem_ack_i,
    output stall_o, flush_o, stall_cycles_o, bus_err_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline scheduler for the 5-stage core. Stall/flush buses are
// combinational from registered state plus current inputs so hazards act in
// the same cycle. Priority: dmem wait > redirect > load-use > squash > imem wait.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REDIR_LAT    = 2,
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [15:0] TMO          = 16'(DMEM_TIMEOUT);
  localparam logic [2:0]  REDIR_RELOAD = 3'(REDIR_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  redir_cnt_q, redir_cnt_d;
  logic [15:0] dwait_cnt_q, dwait_cnt_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  stall_bus_t  stall_s;
  flush_bus_t  flush_s;
  logic        dwait_s;
  logic        timeout_s;
  logic        load_use_s;
  logic [2:0]  squash_base_s;
  logic [15:0] dwait_inc_s;

  assign dwait_s     = hz.mem_access_i & ~hz.dmem_ack_i;
  // The wait has run its full budget: the access is abandoned this cycle
  assign timeout_s   = (state_q == ST_DWAIT) && (dwait_cnt_q >= TMO);
  // An abandoned access also drops any suspended fetch squash
  assign squash_base_s = timeout_s ? 3'd0 : redir_cnt_q;
  assign dwait_inc_s = dwait_cnt_q + 16'd1;
  assign load_use_s  = load_use_hit(hz.ex_mem_re_i, hz.ex_rd_i, hz.id_r1_i, hz.id_use_r1_i,
                                    hz.id_r2_i, hz.id_use_r2_i);

  // Hazard priority resolution: stall/flush buses and next-state values
  always_comb begin
    stall_s     = '0;
    flush_s     = '0;
    state_d     = state_q;
    redir_cnt_d = redir_cnt_q;
    dwait_cnt_d = dwait_cnt_q;
    bus_err_d   = bus_err_q;
    if (dwait_s && !timeout_s) begin
      // Data access outstanding: everything else waits, squash count held
      stall_s     = STALL_DWAIT;
      flush_s     = FLUSH_DWAIT;
      state_d     = ST_DWAIT;
      dwait_cnt_d = dwait_inc_s;
      if (dwait_inc_s == TMO) begin
        bus_err_d = 1'b1;
      end else begin
        bus_err_d = bus_err_q;
      end
    end else begin
      dwait_cnt_d = 16'd0;
      if (hz.ex_redirect_i) begin
        flush_s     = FLUSH_REDIRECT;
        redir_cnt_d = REDIR_RELOAD;
      end else if (load_use_s) begin
        // One-cycle bubble; a pending squash resumes afterwards
        stall_s     = STALL_LOADUSE;
        flush_s     = FLUSH_LOADUSE;
        redir_cnt_d = squash_base_s;
      end else begin
        if (squash_base_s != 3'd0) begin
          flush_s     = FLUSH_SQUASH;
          redir_cnt_d = squash_base_s - 3'd1;
        end else begin
          redir_cnt_d = 3'd0;
        end
        if (!hz.imem_ack_i) begin
          stall_s = STALL_IMEM;
          flush_s = flush_s | FLUSH_SQUASH;
        end else begin
          stall_s = stall_s;
        end
      end
      state_d = (redir_cnt_d != 3'd0) ? ST_REDIR : ST_RUN;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    if (stall_s[STG_PC] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Controller state, counters and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      redir_cnt_q    <= 3'd0;
      dwait_cnt_q    <= 16'd0;
      bus_err_q      <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      redir_cnt_q    <= redir_cnt_d;
      dwait_cnt_q    <= dwait_cnt_d;
      bus_err_q      <= bus_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // While in reset, hold nothing and clear every stage register
  assign hz.stall_o        = rst_n ? stall_s : '0;
  assign hz.flush_o        = rst_n ? flush_s : FLUSH_RESET;
  assign hz.stall_cycles_o = stall_cycles_q;
  assign hz.bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a priority-rule reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 2;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int tests = 0;
  int fails = 0;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.REDIR_LAT(LAT), .DMEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: remaining squash cycles, consecutive wait length,
  // sticky error, stall count
  int     m_squash = 0;
  int     m_wait = 0;
  bit     m_err = 1'b0;
  longint m_stalls = 0;

  typedef struct {
    logic [4:0] st;
    logic [4:0] fl;
    int         nsq;
    int         nwait;
    bit         nerr;
  } mres_t;

  function automatic mres_t eval();
    mres_t r;
    bit lu, waiting, abandoned;
    int sq;
    r.st = 5'h00; r.fl = 5'h00; r.nsq = m_squash; r.nwait = 0; r.nerr = m_err;
    if (!rst_n) begin
      r.fl = 5'h1F; r.nsq = 0; r.nerr = 1'b0;
      return r;
    end
    abandoned = (m_wait == TMO);
    waiting = hz.mem_access_i && !hz.dmem_ack_i && !abandoned;
    lu = hz.ex_mem_re_i && (hz.ex_rd_i != 5'd0) &&
         ((hz.id_use_r1_i && hz.id_r1_i == hz.ex_rd_i) ||
          (hz.id_use_r2_i && hz.id_r2_i == hz.ex_rd_i));
    if (waiting) begin
      r.st = 5'h0F; r.fl = 5'h10;
      r.nwait = m_wait + 1;
      r.nerr = m_err || (r.nwait == TMO);
    end else begin
      sq = abandoned ? 0 : m_squash;
      if (hz.ex_redirect_i) begin
        r.fl = 5'h06; r.nsq = LAT - 1;
      end else if (lu) begin
        r.st = 5'h03; r.fl = 5'h04; r.nsq = sq;
      end else begin
        r.nsq = (sq > 0) ? sq - 1 : 0;
        if (sq > 0) r.fl = 5'h02;
        if (!hz.imem_ack_i) begin
          r.st = 5'h01; r.fl = 5'h02;
        end
      end
    end
    return r;
  endfunction

  // Advance the reference model on each clock edge
  always @(posedge clk or negedge rst_n) begin
    mres_t r;
    if (!rst_n) begin
      m_squash <= 0; m_wait <= 0; m_err <= 1'b0; m_stalls <= 0;
    end else begin
      r = eval();
      m_squash <= r.nsq;
      m_wait   <= r.nwait;
      m_err    <= r.nerr;
      if (r.st[0] && m_stalls < 64'hFFFF_FFFF) m_stalls <= m_stalls + 1;
    end
  end

  // Compare DUT against the model away from the active edge
  always @(negedge clk) begin
    mres_t r;
    r = eval();
    check("model_stall", {27'd0, hz.stall_o}, {27'd0, r.st});
    check("model_flush", {27'd0, hz.flush_o}, {27'd0, r.fl});
    check("model_buserr", {31'd0, hz.bus_err_o}, {31'd0, m_err});
    check("model_stallcnt", hz.stall_cycles_o, 32'(m_stalls));
  end

  task automatic idle();
    hz.id_r1_i = 5'd0; hz.id_r2_i = 5'd0; hz.id_use_r1_i = 1'b0; hz.id_use_r2_i = 1'b0;
    hz.ex_rd_i = 5'd0; hz.ex_mem_re_i = 1'b0; hz.ex_redirect_i = 1'b0;
    hz.mem_access_i = 1'b0; hz.dmem_ack_i = 1'b1; hz.imem_ack_i = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [4:0] st, input logic [4:0] fl);
    #1;
    check({name, "_stall"}, {27'd0, hz.stall_o}, {27'd0, st});
    check({name, "_flush"}, {27'd0, hz.flush_o}, {27'd0, fl});
  endtask

  initial begin
    logic [31:0] sc0;
    idle();
    #1 rst_n = 1'b0;
    #2;
    check("rst_stall", {27'd0, hz.stall_o}, 32'h00);
    check("rst_flush", {27'd0, hz.flush_o}, 32'h1F);
    check("rst_buserr", {31'd0, hz.bus_err_o}, 32'h0);
    check("rst_cnt", hz.stall_cycles_o, 32'h0);
    #9 rst_n = 1'b1;
    tick(); lit("idle", 5'h00, 5'h00);

    // Load-use on rs2, then rs1, then with rd=x0
    tick(); hz.ex_mem_re_i = 1'b1; hz.ex_rd_i = 5'd5; hz.id_r2_i = 5'd5; hz.id_use_r2_i = 1'b1;
    lit("lu_r2", 5'h03, 5'h04);
    tick(); idle(); lit("lu_after", 5'h00, 5'h00);
    tick(); hz.ex_mem_re_i = 1'b1; hz.ex_rd_i = 5'd9; hz.id_r1_i = 5'd9; hz.id_use_r1_i = 1'b1;
    lit("lu_r1", 5'h03, 5'h04);
    tick(); hz.ex_rd_i = 5'd0; hz.id_r1_i = 5'd0; hz.id_r2_i = 5'd0; hz.id_use_r2_i = 1'b1;
    lit("lu_x0", 5'h00, 5'h00);

    // Redirect with simultaneous load-use, then squash
    tick(); idle(); hz.ex_redirect_i = 1'b1;
    hz.ex_mem_re_i = 1'b1; hz.ex_rd_i = 5'd5; hz.id_r2_i = 5'd5; hz.id_use_r2_i = 1'b1;
    lit("redir_c0", 5'h00, 5'h06);
    tick(); idle(); lit("redir_c1", 5'h00, 5'h02);
    tick(); lit("redir_c2", 5'h00, 5'h00);

    // Redirect during squash reloads it
    tick(); hz.ex_redirect_i = 1'b1; lit("reload_a", 5'h00, 5'h06);
    tick(); lit("reload_b", 5'h00, 5'h06);
    tick(); idle(); lit("reload_c", 5'h00, 5'h02);
    tick(); lit("reload_d", 5'h00, 5'h00);

    // dmem wait for 3 cycles with redirect held throughout
    sc0 = hz.stall_cycles_o;
    tick(); hz.mem_access_i = 1'b1; hz.dmem_ack_i = 1'b0; hz.ex_redirect_i = 1'b1;
    lit("dw_1", 5'h0F, 5'h10);
    tick(); lit("dw_2", 5'h0F, 5'h10);
    tick(); lit("dw_3", 5'h0F, 5'h10);
    tick(); hz.dmem_ack_i = 1'b1; lit("dw_ack", 5'h00, 5'h06);
    tick(); idle(); lit("dw_squash", 5'h00, 5'h02);
    check("dw_cnt", hz.stall_cycles_o, sc0 + 32'd3);
    tick(); lit("dw_done", 5'h00, 5'h00);

    // dmem wait suspends an in-progress squash
    tick(); hz.ex_redirect_i = 1'b1; lit("sus_redir", 5'h00, 5'h06);
    tick(); idle(); hz.mem_access_i = 1'b1; hz.dmem_ack_i = 1'b0; lit("sus_w1", 5'h0F, 5'h10);
    tick(); lit("sus_w2", 5'h0F, 5'h10);
    tick(); hz.dmem_ack_i = 1'b1; lit("sus_resume", 5'h00, 5'h02);
    tick(); idle(); lit("sus_done", 5'h00, 5'h00);

    // imem wait in RUN, then inside a squash
    tick(); hz.imem_ack_i = 1'b0; lit("im_1", 5'h01, 5'h02);
    tick(); lit("im_2", 5'h01, 5'h02);
    tick(); idle(); hz.ex_redirect_i = 1'b1; lit("im_redir", 5'h00, 5'h06);
    tick(); idle(); hz.imem_ack_i = 1'b0; lit("im_squash", 5'h01, 5'h02);
    tick(); idle(); lit("im_done", 5'h00, 5'h00);

    // Timeout: 4 wait cycles, then release with sticky bus error
    tick(); hz.mem_access_i = 1'b1; hz.dmem_ack_i = 1'b0; lit("to_1", 5'h0F, 5'h10);
    check("to_err_early", {31'd0, hz.bus_err_o}, 32'h0);
    tick(); tick(); tick(); lit("to_4", 5'h0F, 5'h10);
    check("to_err_4", {31'd0, hz.bus_err_o}, 32'h0);
    tick(); lit("to_release", 5'h00, 5'h00);
    check("to_err_set", {31'd0, hz.bus_err_o}, 32'h1);
    tick(); idle(); tick(); tick();
    check("to_err_sticky", {31'd0, hz.bus_err_o}, 32'h1);

    // Asynchronous reset in the middle of a data wait
    tick(); hz.mem_access_i = 1'b1; hz.dmem_ack_i = 1'b0;
    tick(); tick(); #1 rst_n = 1'b0;
    #1;
    check("arst_stall", {27'd0, hz.stall_o}, 32'h00);
    check("arst_flush", {27'd0, hz.flush_o}, 32'h1F);
    check("arst_buserr", {31'd0, hz.bus_err_o}, 32'h0);
    check("arst_cnt", hz.stall_cycles_o, 32'h0);
    tick(); idle(); rst_n = 1'b1;
    lit("arst_run", 5'h00, 5'h00);
    tick(); hz.imem_ack_i = 1'b0; lit("arst_im", 5'h01, 5'h02);
    tick(); idle(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline scheduler for the 5-stage RV32I core. It drives the per-stage stall and flush buses consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves data-memory waits, load-use hazards, EX-stage control redirects (with a multi-cycle fetch squash) and instruction-fetch waits. It also keeps a stall-cycle counter and a sticky data-bus timeout flag.

Parameters:
REDIR_LAT, 2, cycles IF/ID is flushed after a redirect (fetch pipeline depth); legal 1..7
DMEM_TIMEOUT, 255, max consecutive DWAIT cycles before bus error; legal 1..65535

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous reset, active-low
id_r1_i  in  5  rs1 of the instruction in ID
id_r2_i  in  5  rs2 of the instruction in ID
id_use_r1_i  in  1  ID instruction reads rs1
id_use_r2_i  in  1  ID instruction reads rs2
ex_rd_i  in  5  rd of the instruction in EX (ID/EX output)
ex_mem_re_i  in  1  instruction in EX is a load
ex_redirect_i  in  1  branch taken or jump resolved in EX
mem_access_i  in  1  instruction in MEM performs a load or store
dmem_ack_i  in  1  data memory completes the access this cycle
imem_ack_i  in  1  fetch data valid this cycle
stall_o  out  5  stall bus; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
flush_o  out  5  flush bus, same bit mapping
stall_cycles_o  out  32  cycles with stall_o[0]=1, saturating at 0xFFFFFFFF
bus_err_o  out  1  sticky data-memory timeout

Behaviour:
- Reset: rst_n low asynchronously sets state to RUN, redir_cnt=0, dwait_cnt=0, stall_cycles_o=0 and bus_err_o=0. While rst_n is low, stall_o=0 and flush_o=5'b11111.
- stall_o and flush_o are combinational functions of the registered state and the current inputs (Mealy), so they take effect in the same cycle.
- States:
  - RUN: normal operation.
  - DWAIT: a data access is outstanding.
  - REDIR: the fetch squash is in progress.
- Event priority, highest first:
  1. dmem wait
  2. redirect
  3. load-use
  4. redirect squash
  5. imem wait
- dmem wait: mem_access_i=1 and dmem_ack_i=0, in any state.
  - Outputs: stall_o=5'b01111, flush_o=5'b10000 (bubble into MEM/WB).
  - Next state is DWAIT and dwait_cnt increments; REDIR is suspended with redir_cnt held.
  - On ack, outputs follow the lower-priority rules that same cycle. Next state is REDIR if redir_cnt!=0, else RUN. dwait_cnt clears.
  - All lower-priority events are ignored meanwhile. Their source signals stay valid because the upstream stages are stalled.
- Timeout: when dwait_cnt reaches DMEM_TIMEOUT, bus_err_o is set (cleared only by reset) and the stall releases with the normal dmem-wait outputs dropped. The access is abandoned, and the next state is RUN.
- Redirect: ex_redirect_i=1, not masked by a dmem wait.
  - Outputs: stall_o=0, flush_o=5'b00110 (kill IF/ID and ID/EX; PC loads the target).
  - Overrides load-use.
  - If REDIR_LAT>1: next state is REDIR, redir_cnt=REDIR_LAT-1.
- Load-use: ex_mem_re_i and ex_rd_i!=0 and ((id_use_r1_i and id_r1_i==ex_rd_i) or (id_use_r2_i and id_r2_i==ex_rd_i)).
  - Outputs: stall_o=5'b00011, flush_o=5'b00100.
  - Lasts exactly one cycle; the next cycle the load is in MEM.
- REDIR (no higher event):
  - Outputs: flush_o[1]=1, others 0; stall_o=0.
  - redir_cnt decrements; return to RUN when it reaches 0.
  - A new redirect in REDIR reloads redir_cnt.
- imem wait: imem_ack_i=0 with no higher event.
  - Outputs: stall_o=5'b00001, flush_o=5'b00010.
  - When combined with REDIR, flush_o[1]=1 is unchanged.
- Default: stall_o=0, flush_o=0.
- stall_cycles_o increments on every cycle where stall_o[0]=1.

Decomposition:
- Shared defines header: stall/flush bit indices (STG_PC..STG_WB), StallBus/FlushBus widths, state encodings (RUN=2'd0, DWAIT=2'd1, REDIR=2'd2).
- No sub-module; the saturating counter is inline.

Test Plan:
- Reset:
  - Stimulus: rst_n low mid-DWAIT (dwait_cnt=5).
  - Response: immediately stall_o=0, flush_o=5'h1F, bus_err_o=0, stall_cycles_o=0; after release, state is RUN.
- Load-use:
  - Stimulus: ex_mem_re_i=1, ex_rd_i=5, id_r2_i=5, id_use_r2_i=1.
  - Response: one cycle stall_o=5'h03, flush_o=5'h04. The same stimulus with ex_rd_i=0 gives stall_o=0.
- Redirect:
  - Stimulus: ex_redirect_i pulse, REDIR_LAT=2.
  - Response: cycle0 flush_o=5'h06; cycle1 flush_o=5'h02; cycle2 flush_o=0. Simultaneous load-use in cycle0 is ignored (stall_o=0).
- dmem wait:
  - Stimulus: mem_access_i=1 with dmem_ack_i low for 3 cycles, ex_redirect_i=1 throughout.
  - Response: 3 cycles stall_o=5'h0F, flush_o=5'h10. The cycle ack=1 gives flush_o=5'h06. stall_cycles_o increases by 3.
- Timeout:
  - Stimulus: DMEM_TIMEOUT=4, dmem_ack_i held low.
  - Response: bus_err_o rises after 4 wait cycles, the stall releases, and bus_err_o stays 1 until reset.
- imem wait:
  - Stimulus: imem_ack_i=0 for 2 cycles in RUN.
  - Response: stall_o=5'h01, flush_o=5'h02 each of those cycles; during REDIR, flush_o[1] stays 1.
